// File: rtl/branch_pc_unit_pkg.sv
// branch_pc_unit_pkg: shared FSM encoding, width defaults and IR C-field position for the branch/PC unit
package branch_pc_unit_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int OFF_W_DEF   = 19;
  localparam int C_FIELD_LSB = 0;
  localparam int C_FIELD_MSB = C_FIELD_LSB + OFF_W_DEF - 1;
  typedef enum logic [1:0] {
    BR_IDLE    = 2'd0,
    BR_SAMPLE  = 2'd1,
    BR_RESOLVE = 2'd2
  } br_state_e;
endpackage

// File: rtl/branch_pc_unit_pc_target_adder.sv
// pc_target_adder: sign-extends the branch displacement and adds it to the PC, wrapping modulo 2^ADDR_W
module pc_target_adder #(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 19
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [ADDR_W-1:0] target_o
);
  assign target_o = pc_i + {{(ADDR_W-OFF_W){off_i[OFF_W-1]}}, off_i};
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register plus IDLE->SAMPLE->RESOLVE branch sequencer with latched CON flag.
// Defining BR_STATS_EN adds saturating taken/not-taken branch counters.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                OFF_W    = OFF_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              br_start,
  input  logic [OFF_W-1:0]  br_offset,
  input  logic              con_in,
`ifdef BR_STATS_EN
  output logic [15:0]       br_taken_cnt,
  output logic [15:0]       br_nt_cnt,
`endif
  output logic [ADDR_W-1:0] pc,
  output logic              con_q,
  output logic              busy,
  output logic              br_done,
  output logic              br_taken
);
  br_state_e         state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] pc_q, pc_d, target;
  logic              con_d, done_q, done_d, taken_q, taken_d;

  pc_target_adder #(.ADDR_W(ADDR_W), .OFF_W(OFF_W)) u_adder (
    .pc_i(pc_q), .off_i(off_q), .target_o(target)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    pc_d    = pc_q;
    con_d   = con_q;
    done_d  = 1'b0;
    taken_d = taken_q;
    case (state_q)
      BR_IDLE: begin
        state_d = br_start ? BR_SAMPLE : BR_IDLE;
        off_d   = br_start ? br_offset : off_q;
        pc_d    = pc_load ? pc_load_val : pc_inc ? pc_q + ADDR_W'(1) : pc_q;
      end
      BR_SAMPLE: begin
        state_d = BR_RESOLVE;
        con_d   = con_in;
      end
      BR_RESOLVE: begin
        state_d = BR_IDLE;
        pc_d    = con_q ? target : pc_q;
        done_d  = 1'b1;
        taken_d = con_q;
      end
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= BR_IDLE;
      off_q   <= '0;
      pc_q    <= RESET_PC;
      con_q   <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      pc_q    <= pc_d;
      con_q   <= con_d;
      done_q  <= done_d;
      taken_q <= taken_d;
    end
  end

`ifdef BR_STATS_EN
  logic [15:0] taken_cnt_q, nt_cnt_q;
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else if (state_q == BR_RESOLVE) begin
      if (con_q && taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
      if (!con_q && nt_cnt_q != 16'hFFFF) nt_cnt_q <= nt_cnt_q + 16'd1;
    end
  end
  assign br_taken_cnt = taken_cnt_q;
  assign br_nt_cnt    = nt_cnt_q;
`endif

  assign pc       = pc_q;
  assign busy     = state_q != BR_IDLE;
  assign br_done  = done_q;
  assign br_taken = taken_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed and randomized checks of branch_pc_unit against a PC/branch reference model
module tb_branch_pc_unit;
  logic        clk = 0, clr_n = 0;
  logic        pc_inc = 0, pc_load = 0, br_start = 0, con_in = 0;
  logic [31:0] pc_load_val = '0;
  logic [18:0] br_offset = '0;
  logic [31:0] pc;
  logic        con_q, busy, br_done, br_taken;
  logic [31:0] exp_pc = '0;
  int          n_chk = 0, n_pass = 0, tk = 0, nt = 0;
`ifdef BR_STATS_EN
  logic [15:0] br_taken_cnt, br_nt_cnt;
`endif

  branch_pc_unit dut (
    .clk(clk), .clr_n(clr_n), .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .br_start(br_start), .br_offset(br_offset), .con_in(con_in),
`ifdef BR_STATS_EN
    .br_taken_cnt(br_taken_cnt), .br_nt_cnt(br_nt_cnt),
`endif
    .pc(pc), .con_q(con_q), .busy(busy), .br_done(br_done), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] sext(input logic [18:0] off);
    return off[18] ? 32'(off) - 32'h0008_0000 : 32'(off);
  endfunction

  task automatic load(input logic [31:0] v, input logic also_inc);
    @(negedge clk);
    pc_load = 1; pc_load_val = v; pc_inc = also_inc;
    @(negedge clk);
    pc_load = 0; pc_inc = 0;
    exp_pc = v;
    chk("load", pc, exp_pc);
  endtask

  task automatic inc();
    @(negedge clk);
    pc_inc = 1;
    @(negedge clk);
    pc_inc = 0;
    exp_pc = exp_pc + 1;
    chk("inc", pc, exp_pc);
  endtask

  task automatic do_branch(input logic [18:0] off, input logic c, input logic poke);
    @(negedge clk);
    br_start = 1; br_offset = off; con_in = ~c;
    @(negedge clk);
    chk("busy_sample", busy, 1);
    chk("done_sample", br_done, 0);
    br_start = 0; con_in = c; br_offset = 19'($urandom);
    @(negedge clk);
    chk("con_q", con_q, c);
    chk("busy_resolve", busy, 1);
    con_in = ~c; br_start = poke; pc_inc = poke; pc_load = poke; pc_load_val = $urandom;
    @(negedge clk);
    br_start = 0; pc_inc = 0; pc_load = 0;
    if (c) exp_pc = exp_pc + sext(off);
    if (c) tk++; else nt++;
    chk("pc_resolved", pc, exp_pc);
    chk("done_pulse", br_done, 1);
    chk("taken", br_taken, c);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    chk("done_clear", br_done, 0);
    chk("pc_hold", pc, exp_pc);
    chk("taken_hold", br_taken, c);
    chk("busy_after", busy, 0);
    chk("con_hold", con_q, c);
  endtask

  initial begin
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_con", con_q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", br_done, 0);
    chk("rst_taken", br_taken, 0);
    @(negedge clk) clr_n = 1;
    load(32'h10, 0);
    // async reset while a branch sits in SAMPLE
    @(negedge clk);
    br_start = 1; br_offset = 19'h5; con_in = 1;
    @(posedge clk);
    #2 clr_n = 0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_con", con_q, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", br_done, 0);
    @(negedge clk);
    br_start = 0; clr_n = 1;
    exp_pc = 0;
    repeat (3) @(negedge clk);
    chk("arst_abandon_pc", pc, 0);
    chk("arst_abandon_done", br_done, 0);
    load(32'h10, 0);
    do_branch(19'h00005, 1, 0);
    chk("taken_0x15", pc, 32'h15);
    load(32'h10, 0);
    do_branch(19'h00005, 0, 0);
    chk("nt_0x10", pc, 32'h10);
    load(32'h2, 0);
    do_branch(19'h7FFFC, 1, 0);
    chk("wrap", pc, 32'hFFFF_FFFE);
    load(32'h40, 1);
    chk("load_prio", pc, 32'h40);
    do_branch(19'h00003, 1, 1);
    @(negedge clk);
    chk("no_second_done", br_done, 0);
    chk("ignored_busy_ops", pc, 32'h43);
    @(negedge clk);
    chk("idle_hold", pc, exp_pc);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: load($urandom, 1'($urandom));
        1: inc();
        default: do_branch($urandom_range(0, 1) ? 19'($urandom) : 19'($urandom_range(0, 15)),
                           1'($urandom), 1'($urandom));
      endcase
    end
`ifdef BR_STATS_EN
    chk("cnt_taken", 32'(br_taken_cnt), 32'(tk));
    chk("cnt_nt", 32'(br_nt_cnt), 32'(nt));
    @(negedge clk);
    force dut.taken_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.taken_cnt_q;
    do_branch(19'h1, 1, 0);
    chk("cnt_sat", 32'(br_taken_cnt), 32'hFFFF);
    chk("cnt_nt_final", 32'(br_nt_cnt), 32'(nt));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
